// File: rtl/reg_file.sv
// 32 x WIDTH register file with a post-reset clearing sweep; register 0 is hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module reg_file #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ra1,
  input  logic [4:0]       ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  input  logic             we3,
  input  logic [4:0]       wa3,
  input  logic [WIDTH-1:0] wd3,
  output logic             ready
);

  typedef enum logic {
    CLEAR,
    RUN
  } state_e;

  state_e           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] regs_q [32];
  logic [WIDTH-1:0] regs_d [32];
  logic             run;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    regs_d  = regs_q;
    case (state_q)
      CLEAR: begin
        regs_d[cnt_q] = '0;
        if (cnt_q == 5'd31) begin
          state_d = RUN;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      RUN: begin
        if (we3 && (wa3 != 5'd0)) regs_d[wa3] = wd3;
      end
    endcase
  end

  // Reset also blocks the storage update, so a write in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= 5'd1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      regs_q  <= regs_d;
    end
  end

  assign run   = (state_q == RUN) && !rst;
  assign ready = ready_q && !rst;

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (run && (ra1 != 5'd0)) rd1 = regs_q[ra1];
    if (run && (ra2 != 5'd0)) rd2 = regs_q[ra2];
`ifdef REGFILE_BYPASS_EN
    if (run && we3 && (wa3 != 5'd0) && (ra1 == wa3)) rd1 = wd3;
    if (run && we3 && (wa3 != 5'd0) && (ra2 == wa3)) rd2 = wd3;
`endif
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: clearing sequence, writes, register 0,
// forwarding, resets during clear and run.
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic [4:0]  ra1, ra2, wa3;
  logic [31:0] rd1, rd2, wd3;
  logic        we3;
  logic        ready;

  int checks;
  int failures;

  reg_file #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .ra1  (ra1),
    .ra2  (ra2),
    .rd1  (rd1),
    .rd2  (rd2),
    .we3  (we3),
    .wa3  (wa3),
    .wd3  (wd3),
    .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; we3 = 1'b0; ra1 = 5'd4; ra2 = 5'd9;
    tick();
    checks++;
    if (ready !== 1'b0 || rd1 !== 32'd0 || rd2 !== 32'd0) begin
      failures++;
      $display("FAIL reset_hold: ready=%b rd1=%h rd2=%h required ready=0 rd1=0 rd2=0", ready, rd1, rd2);
    end
    rst = 1'b0;
    for (int e = 1; e <= 31; e++) begin
      ra1 = 5'(e); ra2 = 5'(31 - e);
      tick();
      checks++;
      if (e < 31) begin
        if (ready !== 1'b0 || rd1 !== 32'd0 || rd2 !== 32'd0) begin
          failures++;
          $display("FAIL reset_clear_edge%0d: ready=%b rd1=%h rd2=%h required 0/0/0", e, ready, rd1, rd2);
        end
      end else if (ready !== 1'b1) begin
        failures++;
        $display("FAIL reset_ready_rise: ready=%b required 1", ready);
      end
    end
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); ra2 = 5'(31 - a);
      #1;
      checks++;
      if (rd1 !== 32'd0 || rd2 !== 32'd0) begin
        failures++;
        $display("FAIL reset_all_zero_a%0d: rd1=%h rd2=%h required 0", a, rd1, rd2);
      end
    end
  endtask

  task automatic test_write_read();
    we3 = 1'b1; wa3 = 5'd5; wd3 = 32'h0000_00A5;
    tick();
    we3 = 1'b0; ra1 = 5'd5; ra2 = 5'd6;
    #1;
    checks++;
    if (rd1 !== 32'h0000_00A5) begin
      failures++;
      $display("FAIL write_read_rd1: rd1=%h required 000000a5", rd1);
    end
    checks++;
    if (rd2 !== 32'd0) begin
      failures++;
      $display("FAIL write_read_rd2: rd2=%h required 0", rd2);
    end
    ra2 = 5'd5;
    #1;
    checks++;
    if (rd2 !== 32'h0000_00A5 || rd1 !== rd2) begin
      failures++;
      $display("FAIL same_addr: rd1=%h rd2=%h required both 000000a5", rd1, rd2);
    end
  endtask

  task automatic test_reg0();
    we3 = 1'b1; wa3 = 5'd0; wd3 = 32'hFFFF_FFFF; ra1 = 5'd0; ra2 = 5'd0;
    #1;
    checks++;
    if (rd1 !== 32'd0 || rd2 !== 32'd0) begin
      failures++;
      $display("FAIL reg0_before: rd1=%h rd2=%h required 0", rd1, rd2);
    end
    tick();
    we3 = 1'b0;
    #1;
    checks++;
    if (rd1 !== 32'd0 || rd2 !== 32'd0) begin
      failures++;
      $display("FAIL reg0_after: rd1=%h rd2=%h required 0", rd1, rd2);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_same;
    we3 = 1'b1; wa3 = 5'd7; wd3 = 32'h0000_0011;
    tick();
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'h1234_5678;
`else
    exp_same = 32'h0000_0011;
`endif
    wd3 = 32'h1234_5678; ra1 = 5'd7; ra2 = 5'd5;
    #1;
    checks++;
    if (rd1 !== exp_same) begin
      failures++;
      $display("FAIL bypass_same_cycle: rd1=%h required %h", rd1, exp_same);
    end
    checks++;
    if (rd2 !== 32'h0000_00A5) begin
      failures++;
      $display("FAIL bypass_other_port: rd2=%h required 000000a5", rd2);
    end
    tick();
    we3 = 1'b0;
    #1;
    checks++;
    if (rd1 !== 32'h1234_5678) begin
      failures++;
      $display("FAIL bypass_after_edge: rd1=%h required 12345678", rd1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [4];
    vals[0] = 32'hCAFE_0001; vals[1] = 32'h8000_0000;
    vals[2] = 32'h0F0F_0F0F; vals[3] = 32'h7FFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      we3 = 1'b1; wa3 = 5'(i + 28); wd3 = vals[i];
      tick();
    end
    we3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ra1 = 5'(i + 28); ra2 = 5'(31 - i);
      #1;
      checks++;
      if (rd1 !== vals[i] || rd2 !== vals[3 - i]) begin
        failures++;
        $display("FAIL back_to_back_%0d: rd1=%h rd2=%h required %h %h", i, rd1, rd2, vals[i], vals[3 - i]);
      end
    end
  endtask

  task automatic test_rst_in_run();
    rst = 1'b1; we3 = 1'b1; wa3 = 5'd9; wd3 = 32'h5555_AAAA; ra1 = 5'd7; ra2 = 5'd5;
    #1;
    checks++;
    if (ready !== 1'b0 || rd1 !== 32'd0 || rd2 !== 32'd0) begin
      failures++;
      $display("FAIL rst_run_outputs: ready=%b rd1=%h rd2=%h required 0/0/0", ready, rd1, rd2);
    end
    tick();
    rst = 1'b0; we3 = 1'b0;
    for (int e = 1; e <= 31; e++) tick();
    ra1 = 5'd9; ra2 = 5'd7;
    #1;
    checks++;
    if (ready !== 1'b1 || rd1 !== 32'd0 || rd2 !== 32'd0) begin
      failures++;
      $display("FAIL rst_run_cleared: ready=%b rd1=%h rd2=%h required 1/0/0", ready, rd1, rd2);
    end
  endtask

  task automatic test_mid_clear_reset();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int e = 1; e <= 9; e++) tick();
    rst = 1'b1; tick();
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_clear_rst_ready: ready=%b required 0", ready);
    end
    rst = 1'b0;
    for (int e = 1; e <= 31; e++) begin
      tick();
      checks++;
      if (e < 31 && ready !== 1'b0) begin
        failures++;
        $display("FAIL mid_clear_edge%0d: ready=%b required 0", e, ready);
      end else if (e == 31 && ready !== 1'b1) begin
        failures++;
        $display("FAIL mid_clear_ready_rise: ready=%b required 1", ready);
      end
    end
  endtask

  task automatic test_write_during_clear();
    we3 = 1'b1; wa3 = 5'd2; wd3 = 32'h0000_0077;
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    wa3 = 5'd3; wd3 = 32'hDEAD_BEEF; ra1 = 5'd3;
    for (int e = 1; e <= 31; e++) begin
      tick();
      if (e == 15) begin
        checks++;
        if (rd1 !== 32'd0) begin
          failures++;
          $display("FAIL clear_read_zero: rd1=%h required 0", rd1);
        end
      end
    end
    we3 = 1'b0; ra1 = 5'd3; ra2 = 5'd2;
    #1;
    checks++;
    if (ready !== 1'b1 || rd1 !== 32'd0 || rd2 !== 32'd0) begin
      failures++;
      $display("FAIL write_during_clear: ready=%b reg3=%h reg2=%h required 1/0/0", ready, rd1, rd2);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; we3 = 1'b0; wa3 = '0; wd3 = '0; ra1 = '0; ra2 = '0;
    #2;
    test_reset();
    test_write_read();
    test_reg0();
    test_bypass();
    test_back_to_back();
    test_rst_in_run();
    test_mid_clear_reset();
    test_write_during_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
